game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Two-player turn sequencer for the dice game. It owns the game state machine and shares the single Start/Roll/Choose datapath between player 0 and player 1. It generates one-hot enables for those submodules, muxes the active player's score into Choose, and latches Choose's result back into per-player score registers. It counts rounds and declares a winner; outputs drive the Digit displays and LEDs at the top level.

Parameters:
TARGET, 9, score at or above which the active player wins immediately (4-bit compare)
MAX_ROUNDS, 5, rounds (both players played) before the game ends on points
TIMEOUT_CYCLES, 500000000, idle cycles in ROLL/CHOOSE before forced pass (TIMEOUT_EN only)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous, active-high reset
start_pulse  in  1  one-cycle pulse from Start submodule
roll_pulse  in  1  one-cycle pulse from Roll (die value settled)
choose_pulse  in  1  one-cycle pulse from Choose (decision confirmed)
choose_result  in  2  00 keep, 01 bust, 1x treated as keep
new_score  in  4  score computed by Choose, valid with choose_pulse
enable  out  4  one-hot: [0] Start, [1] Roll, [2] Choose, [3] unused (0)
cur_score  out  4  active player's score, fed to Choose score input
player  out  1  active player index
score0  out  4  player 0 score
score1  out  4  player 1 score
rounds  out  4  completed rounds
game_over  out  1  high in DONE
winner  out  2  00 none, 01 P0, 10 P1, 11 tie

Behaviour:
- States: IDLE, ROLL, CHOOSE, CHECK, DONE. All outputs registered.
- Reset (rst high at posedge, any state): state IDLE, enable 4'b0001, player 0, score0/score1/rounds 0, game_over 0, winner 00. Reset mid-game discards all progress.
- enable is decoded from state: IDLE->0001, ROLL->0010, CHOOSE->0100, CHECK/DONE->0000.
- Pulses are accepted only when the matching enable bit is high in that cycle; all others are ignored.
- IDLE: start_pulse -> ROLL next cycle.
- ROLL: roll_pulse -> CHOOSE next cycle.
- CHOOSE: on choose_pulse, the active player's score <= (choose_result==01) ? 0 : new_score; state -> CHECK. Update visible next cycle.
- CHECK (exactly 1 cycle):
  - If the active score >= TARGET: DONE, winner = active player.
  - Else if player==1: rounds++. If rounds+1 == MAX_ROUNDS, go to DONE with winner by comparison (higher wins, equal -> 11). Otherwise player <= 0, ROLL.
  - Else (player 0): player <= 1, ROLL.
- Latency: choose_pulse to the next ROLL enable = 2 cycles.
- DONE: enable 0000, game_over 1. Holds until start_pulse would be ignored (enable[0]=0), so only rst exits DONE.
- rounds saturates at 15 and never wraps. Scores are 4-bit and taken verbatim from new_score; no arithmetic is performed here.
- cur_score = player ? score1 : score0, combinational from registers.

Optional Feature:
TURN_TIMEOUT_EN
- Defined: a 29-bit idle counter clears on every state change and counts while in ROLL or CHOOSE. When it reaches TIMEOUT_CYCLES-1, the block forces CHECK with the score unchanged, so the turn passes and normal CHECK rules apply. A real pulse arriving in the same cycle wins over the timeout.
- Undefined: no counter; ROLL/CHOOSE wait indefinitely. TIMEOUT_CYCLES is unused.

Test Plan:
- Reset then start_pulse -> enable 0001 then 0010 one cycle later; player 0, all scores 0.
- P0: roll_pulse, then choose_pulse with new_score=4, result=00 -> score0=4 one cycle later, CHECK, then ROLL with player 1 and rounds 0.
- P1 choose with new_score=9 (TARGET=9) -> DONE, winner 10, game_over 1, enable 0000; further pulses change nothing.
- MAX_ROUNDS=2, scores reach P0=3, P1=3 with no target hit -> after the 2nd P1 turn, rounds=2, DONE, winner 11.
- Bust: score0=6, choose_result=01 with new_score=8 -> score0=0. roll_pulse asserted during CHOOSE -> ignored.
- TURN_TIMEOUT_EN with TIMEOUT_CYCLES=16: idle in ROLL for 16 cycles -> CHECK, then player toggles with scores unchanged. Pulse on the timeout cycle -> pulse path taken. rst asserted in CHOOSE -> IDLE with all values reset next cycle.

Source files
------------

// File: rtl/game_sequencer_if.sv
// Pulse/score bundle between the dice submodules and the turn sequencer.
// The sequencer takes the slave side; the submodules drive the master side.
interface game_sequencer_if;
   logic       start_pulse;
   logic       roll_pulse;
   logic       choose_pulse;
   logic [1:0] choose_result;
   logic [3:0] new_score;
   logic [3:0] enable;
   logic [3:0] cur_score;
   logic       player;
   logic [3:0] score0;
   logic [3:0] score1;
   logic [3:0] rounds;
   logic       game_over;
   logic [1:0] winner;

   modport master (
      output start_pulse,
      output roll_pulse,
      output choose_pulse,
      output choose_result,
      output new_score,
      input  enable,
      input  cur_score,
      input  player,
      input  score0,
      input  score1,
      input  rounds,
      input  game_over,
      input  winner
   );

   modport slave (
      input  start_pulse,
      input  roll_pulse,
      input  choose_pulse,
      input  choose_result,
      input  new_score,
      output enable,
      output cur_score,
      output player,
      output score0,
      output score1,
      output rounds,
      output game_over,
      output winner
   );
endinterface

// File: rtl/game_sequencer.sv
// Two-player turn sequencer sharing the Start/Roll/Choose datapath.
// Optional TURN_TIMEOUT_EN: idle ROLL/CHOOSE turns are forced to CHECK.
module game_sequencer #(
   parameter int unsigned TARGET         = 9,
   parameter int unsigned MAX_ROUNDS     = 5,
   parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
   input logic             clk,
   input logic             rst,
   game_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE,
      ROLL,
      CHOOSE,
      CHECK,
      DONE
   } state_t;

   localparam logic [3:0] TGT  = 4'(TARGET);
   localparam logic [4:0] MAXR = 5'(MAX_ROUNDS);

   state_t     state, state_n;
   logic       player, player_n;
   logic [3:0] score0, score0_n;
   logic [3:0] score1, score1_n;
   logic [3:0] rounds, rounds_n;
   logic [3:0] enable, enable_n;
   logic       game_over, game_over_n;
   logic [1:0] winner, winner_n;
   logic [3:0] act;
   logic [3:0] kept;
   logic [1:0] cmp_win;
   logic       tmo;

`ifdef TURN_TIMEOUT_EN
   logic [28:0] idle_cnt;

   assign tmo = (idle_cnt == 29'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst || (state_n != state))
         idle_cnt <= '0;
      else if ((state == ROLL) || (state == CHOOSE))
         idle_cnt <= idle_cnt + 29'd1;
   end
`else
   logic unused_timeout;

   assign tmo            = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   assign act  = player ? score1 : score0;
   // A bust zeroes the turn; 1x result codes behave as keep.
   assign kept = (bus.choose_result == 2'b01) ? 4'd0 : bus.new_score;

   always_comb begin
      cmp_win = 2'b11;
      if (score0 > score1)
         cmp_win = 2'b01;
      else if (score1 > score0)
         cmp_win = 2'b10;
   end

   always_comb begin
      state_n  = state;
      player_n = player;
      score0_n = score0;
      score1_n = score1;
      rounds_n = rounds;
      winner_n = winner;
      unique case (state)
         IDLE: begin
            if (bus.start_pulse && enable[0])
               state_n = ROLL;
         end
         ROLL: begin
            if (bus.roll_pulse && enable[1])
               state_n = CHOOSE;
            else if (tmo)
               state_n = CHECK;
         end
         CHOOSE: begin
            if (bus.choose_pulse && enable[2]) begin
               state_n = CHECK;
               if (player)
                  score1_n = kept;
               else
                  score0_n = kept;
            end else if (tmo) begin
               state_n = CHECK;
            end
         end
         CHECK: begin
            if (act >= TGT) begin
               state_n  = DONE;
               winner_n = player ? 2'b10 : 2'b01;
            end else if (player) begin
               if (rounds != 4'hf)
                  rounds_n = rounds + 4'd1;
               if (({1'b0, rounds} + 5'd1) == MAXR) begin
                  state_n  = DONE;
                  winner_n = cmp_win;
               end else begin
                  player_n = 1'b0;
                  state_n  = ROLL;
               end
            end else begin
               player_n = 1'b1;
               state_n  = ROLL;
            end
         end
         DONE: begin
            state_n = DONE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_comb begin
      enable_n = 4'b0000;
      unique case (1'b1)
         (state_n == IDLE):   enable_n = 4'b0001;
         (state_n == ROLL):   enable_n = 4'b0010;
         (state_n == CHOOSE): enable_n = 4'b0100;
         default:             enable_n = 4'b0000;
      endcase
      game_over_n = (state_n == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         enable    <= 4'b0001;
         player    <= 1'b0;
         score0    <= 4'd0;
         score1    <= 4'd0;
         rounds    <= 4'd0;
         game_over <= 1'b0;
         winner    <= 2'b00;
      end else begin
         state     <= state_n;
         enable    <= enable_n;
         player    <= player_n;
         score0    <= score0_n;
         score1    <= score1_n;
         rounds    <= rounds_n;
         game_over <= game_over_n;
         winner    <= winner_n;
      end
   end

   assign bus.enable    = enable;
   assign bus.cur_score = act;
   assign bus.player    = player;
   assign bus.score0    = score0;
   assign bus.score1    = score1;
   assign bus.rounds    = rounds;
   assign bus.game_over = game_over;
   assign bus.winner    = winner;
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed vector table, random play vs a
// game-rule model, and timeout sequences when TURN_TIMEOUT_EN is set.
module tb_game_sequencer;
   localparam int TGT = 9;
   localparam int MR  = 2;
   localparam int TO  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   game_sequencer_if bus ();

   game_sequencer #(
      .TARGET(TGT),
      .MAX_ROUNDS(MR),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   // game-rule model: phase 0 lobby, 1 rolling, 2 choosing, 3 judging, 4 over
   int ph    = 0;
   int pl    = 0;
   int sc[2] = '{0, 0};
   int rnd   = 0;
   int win   = 0;
   int dwell = 0;

   typedef struct packed {
      logic       r, sp, rp, cp;
      logic [1:0] cr;
      logic [3:0] ns;
      logic [3:0] en;
      logic       p;
      logic [3:0] s0, s1, rd;
      logic       ov;
      logic [1:0] w;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic r, sp, rp, cp,
      input logic [1:0] cr,
      input logic [3:0] ns, en,
      input logic p,
      input logic [3:0] s0, s1, rd,
      input logic ov,
      input logic [1:0] w);
      vec_t v;
      v = '{r, sp, rp, cp, cr, ns, en, p, s0, s1, rd, ov, w};
      return v;
   endfunction

   task automatic chk(input string nm,
                      input logic [7:0] act,
                      input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, sp, rp, cp,
                        input logic [1:0] cr,
                        input logic [3:0] ns);
      rst               = r;
      bus.start_pulse   = sp;
      bus.roll_pulse    = rp;
      bus.choose_pulse  = cp;
      bus.choose_result = cr;
      bus.new_score     = ns;
   endtask

   task automatic model_step();
      int  ph0;
      bit  to;
      bit  last;
      ph0 = ph;
      to  = 1'b0;
`ifdef TURN_TIMEOUT_EN
      to = (dwell == TO - 1);
`endif
      if (rst) begin
         ph = 0; pl = 0; sc[0] = 0; sc[1] = 0; rnd = 0; win = 0;
      end else begin
         case (ph)
            0: if (bus.start_pulse) ph = 1;
            1: begin
               if (bus.roll_pulse) ph = 2;
               else if (to) ph = 3;
            end
            2: begin
               if (bus.choose_pulse) begin
                  sc[pl] = (bus.choose_result == 2'b01) ? 0
                           : int'(bus.new_score);
                  ph = 3;
               end else if (to) begin
                  ph = 3;
               end
            end
            3: begin
               if (sc[pl] >= TGT) begin
                  ph = 4; win = (pl == 1) ? 2 : 1;
               end else if (pl == 1) begin
                  last = (rnd + 1 == MR);
                  rnd  = (rnd < 15) ? rnd + 1 : 15;
                  if (last) begin
                     ph  = 4;
                     win = (sc[0] > sc[1]) ? 1 : (sc[1] > sc[0]) ? 2 : 3;
                  end else begin
                     pl = 0; ph = 1;
                  end
               end else begin
                  pl = 1; ph = 1;
               end
            end
            default: ;
         endcase
      end
      if (rst || ph != ph0) dwell = 0;
      else if (ph == 1 || ph == 2) dwell++;
   endtask

   task automatic step();
      logic [3:0] een;
      @(posedge clk);
      #1;
      model_step();
      een = (ph < 3) ? 4'(1 << ph) : 4'd0;
      chk("enable", 8'(bus.enable), 8'(een));
      chk("player", 8'(bus.player), 8'(pl));
      chk("score0", 8'(bus.score0), 8'(sc[0]));
      chk("score1", 8'(bus.score1), 8'(sc[1]));
      chk("rounds", 8'(bus.rounds), 8'(rnd));
      chk("game_over", 8'(bus.game_over), 8'(ph == 4));
      chk("winner", 8'(bus.winner), 8'(win));
      chk("cur_score", 8'(bus.cur_score), 8'(sc[pl]));
   endtask

   initial begin
      vec_t v;
      drive(1, 0, 0, 0, 2'd0, 4'd0);

      tbl.push_back(mk(1,0,0,0,0,0, 1,0, 0,0,0, 0,0));
      tbl.push_back(mk(0,1,0,0,0,0, 2,0, 0,0,0, 0,0));
      tbl.push_back(mk(0,1,1,1,0,5, 4,0, 0,0,0, 0,0));
      tbl.push_back(mk(0,0,1,0,0,0, 4,0, 0,0,0, 0,0));
      tbl.push_back(mk(0,0,0,1,0,4, 0,0, 4,0,0, 0,0));
      tbl.push_back(mk(0,0,0,0,0,0, 2,1, 4,0,0, 0,0));
      tbl.push_back(mk(0,0,1,0,0,0, 4,1, 4,0,0, 0,0));
      tbl.push_back(mk(0,0,0,1,0,9, 0,1, 4,9,0, 0,0));
      tbl.push_back(mk(0,0,0,0,0,0, 0,1, 4,9,0, 1,2));
      tbl.push_back(mk(0,1,1,1,0,3, 0,1, 4,9,0, 1,2));
      tbl.push_back(mk(1,0,0,0,0,0, 1,0, 0,0,0, 0,0));
      tbl.push_back(mk(0,1,0,0,0,0, 2,0, 0,0,0, 0,0));
      tbl.push_back(mk(0,0,1,0,0,0, 4,0, 0,0,0, 0,0));
      tbl.push_back(mk(0,0,0,1,0,6, 0,0, 6,0,0, 0,0));
      tbl.push_back(mk(0,0,0,0,0,0, 2,1, 6,0,0, 0,0));
      tbl.push_back(mk(0,0,1,0,0,0, 4,1, 6,0,0, 0,0));
      tbl.push_back(mk(0,0,0,1,0,3, 0,1, 6,3,0, 0,0));
      tbl.push_back(mk(0,0,0,0,0,0, 2,0, 6,3,1, 0,0));
      tbl.push_back(mk(0,0,1,0,0,0, 4,0, 6,3,1, 0,0));
      tbl.push_back(mk(0,0,0,1,1,8, 0,0, 0,3,1, 0,0));
      tbl.push_back(mk(0,0,0,0,0,0, 2,1, 0,3,1, 0,0));
      tbl.push_back(mk(0,0,1,0,0,0, 4,1, 0,3,1, 0,0));
      tbl.push_back(mk(0,0,0,1,3,0, 0,1, 0,0,1, 0,0));
      tbl.push_back(mk(0,0,0,0,0,0, 0,1, 0,0,2, 1,3));
      tbl.push_back(mk(1,0,0,0,0,0, 1,0, 0,0,0, 0,0));
      tbl.push_back(mk(0,1,0,0,0,0, 2,0, 0,0,0, 0,0));
      tbl.push_back(mk(0,0,1,0,0,0, 4,0, 0,0,0, 0,0));
      tbl.push_back(mk(0,0,0,1,2,12, 0,0, 12,0,0, 0,0));
      tbl.push_back(mk(0,0,0,0,0,0, 0,0, 12,0,0, 1,1));

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         drive(v.r, v.sp, v.rp, v.cp, v.cr, v.ns);
         step();
         chk($sformatf("vec%0d.enable", i), 8'(bus.enable), 8'(v.en));
         chk($sformatf("vec%0d.player", i), 8'(bus.player), 8'(v.p));
         chk($sformatf("vec%0d.score0", i), 8'(bus.score0), 8'(v.s0));
         chk($sformatf("vec%0d.score1", i), 8'(bus.score1), 8'(v.s1));
         chk($sformatf("vec%0d.rounds", i), 8'(bus.rounds), 8'(v.rd));
         chk($sformatf("vec%0d.over", i), 8'(bus.game_over), 8'(v.ov));
         chk($sformatf("vec%0d.winner", i), 8'(bus.winner), 8'(v.w));
      end

      for (int i = 0; i < 3000; i++) begin
         logic r;
         r = (ph == 4) ? ($urandom_range(0, 7) == 0)
                       : ($urandom_range(0, 199) == 0);
         drive(r,
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 2) == 0),
               2'($urandom_range(0, 3)),
               4'($urandom_range(0, 15)));
         step();
      end

`ifdef TURN_TIMEOUT_EN
      drive(1, 0, 0, 0, 2'd0, 4'd0);
      step();
      drive(0, 1, 0, 0, 2'd0, 4'd0);
      step();
      drive(0, 0, 0, 0, 2'd0, 4'd0);
      for (int i = 0; i < TO - 1; i++) begin
         step();
         chk("to.wait_roll", 8'(bus.enable), 8'h02);
      end
      step();
      chk("to.forced_check", 8'(bus.enable), 8'h00);
      step();
      chk("to.next_player", 8'(bus.player), 8'h01);
      chk("to.next_roll", 8'(bus.enable), 8'h02);
      chk("to.score0_kept", 8'(bus.score0), 8'h00);
      for (int i = 0; i < TO - 1; i++) step();
      drive(0, 0, 1, 0, 2'd0, 4'd0);
      step();
      chk("to.pulse_wins", 8'(bus.enable), 8'h04);
      drive(1, 0, 0, 1, 2'd0, 4'd7);
      step();
      chk("to.rst_enable", 8'(bus.enable), 8'h01);
      chk("to.rst_player", 8'(bus.player), 8'h00);
      chk("to.rst_score1", 8'(bus.score1), 8'h00);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
